serial_addsub: RTL and testbench
================================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: start  input  1  request a new operation; sampled on the rising edge.
REQ-005 Port: mode  input  1  operation select: 0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 Port: a  input  WIDTH  operand A; sampled with start.
REQ-007 Port: b  input  WIDTH  operand B; sampled with start.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; result, cout and ovf are valid.
REQ-010 Port: result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-011 Port: cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
REQ-012 Port: ovf  output  1  two's-complement signed overflow.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE or DONE with start=1, the block SHALL latch a, latch b (bitwise inverted if mode=1), set carry to mode, clear the bit counter and enter RUN.
REQ-015 In RUN, each cycle SHALL add one bit pair, LSB first, through a single 1-bit full-adder cell, shift the sum bit into the result register from the MSB side, and register the carry.
REQ-016 After exactly WIDTH RUN cycles, the FSM SHALL enter DONE; busy SHALL be high in every RUN cycle and only then.
REQ-017 done SHALL be high only in DONE, for exactly one cycle; without a new start, DONE SHALL return to IDLE.
REQ-018 Latency: with start sampled at edge 0, done SHALL be high in the cycle following edge WIDTH+1.
REQ-019 cout SHALL equal the final carry; ovf SHALL equal (carry into the MSB) XOR (carry out of the MSB).
REQ-020 result, cout and ovf SHALL hold their values from DONE until the next accepted start.
REQ-021 A start during RUN SHALL be ignored and SHALL not disturb the operands, counter or carry.
REQ-022 A start in the DONE cycle SHALL be accepted; done SHALL still pulse for the completed operation.
REQ-023 Changes to a, b or mode while busy SHALL have no effect on the operation in progress.

Reset
REQ-024 With rst=1 at a rising edge, the FSM SHALL enter IDLE and clear busy, done, result, cout, ovf, the carry and the counter to 0.
REQ-025 rst SHALL override start in the same cycle.
REQ-026 rst asserted mid-RUN SHALL abandon the operation without a done pulse.

Structure
REQ-027 A shared package serial_addsub_pkg SHALL hold the state enumeration and the constants MODE_ADD=0 and MODE_SUB=1.
REQ-028 The 1-bit adder SHALL be a separate sub-module, fa_cell (inputs x, y, ci; outputs s, co), instantiated once.
REQ-029 The counter width SHALL be $clog2(WIDTH+1); no other arithmetic operator SHALL perform the addition.

Verification (WIDTH=8)
REQ-030 add 0x0F+0x01 -> result=0x10, cout=0, ovf=0; done in the cycle after edge 9.
REQ-031 add 0xFF+0x01 -> result=0x00, cout=1, ovf=0; add 0x7F+0x01 -> result=0x80, cout=0, ovf=1.
REQ-032 sub 0x05-0x07 -> result=0xFE, cout=0, ovf=0; sub 0x80-0x01 -> result=0x7F, cout=1, ovf=1.
REQ-033 Start add 0x10+0x20, then pulse start with sub 0x01-0x01 during RUN -> single done, result=0x30; busy stays high for exactly 8 cycles.
REQ-034 rst at the 4th RUN cycle -> next cycle busy=0, done=0 and result=0 with no done pulse; a following add 0x03+0x04 -> result=0x07.
REQ-035 Back-to-back: start held high through DONE -> a second operation starts in the DONE cycle; both done pulses occur with correct results; plus exhaustive random-vs-model check at WIDTH=4.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Single-bit full adder used as the only addition element of the serial datapath.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: one bit pair per cycle, LSB first, through one full adder.
// busy/done are registered one cycle behind the FSM, so with start taken at
// edge 0 the done pulse appears in the cycle after edge WIDTH+1.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;
    logic             fa_s;
    logic             fa_co;
    logic             busy_nxt;
    logic             done_nxt;

    // A new operation is only taken when nothing is running.
    assign accept = start && (state != RUN);
    // Final bit pair is being added this cycle.
    assign last   = (cnt == CW'(WIDTH - 1));

    fa_cell u_fa (
        .x  (opa[0]),
        .y  (opb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status decode from the current state.
    always_comb begin
        busy_nxt = (state == RUN);
        done_nxt = (state == DONE);
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end

    // Operand shift registers, carry, bit counter and result shift-in.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            // Subtract is a + ~b + 1: invert b and seed the carry with mode.
            opa   <= a;
            opb   <= (mode == MODE_SUB) ? ~b : b;
            carry <= mode;
            cnt   <= '0;
        end else if (state == RUN) begin
            opa    <= opa >> 1;
            opb    <= opb >> 1;
            carry  <= fa_co;
            cnt    <= cnt + CW'(1);
            result <= {fa_s, result[WIDTH-1:1]};
            if (last) begin
                // carry still holds the carry into the MSB here.
                cout <= fa_co;
                ovf  <= carry ^ fa_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench: directed vectors on an 8-bit instance with a cycle model,
// plus an exhaustive sweep of a 4-bit instance against an arithmetic reference.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, mode;
    logic [W-1:0] a, b, result;
    logic         busy, done, cout, ovf;

    logic         start4, mode4;
    logic [3:0]   a4, b4, result4;
    logic         busy4, done4, cout4, ovf4;

    int checks = 0;
    int passed = 0;
    logic chk_en = 1'b0;

    serial_addsub #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
    );

    serial_addsub #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference arithmetic: returns {cout, ovf, result} from plain integer math.
    function automatic logic [33:0] ref_op(input int w, input logic m, input longint x, input longint y);
        longint md, half, full, r, sx, sy, sr;
        logic c, v;
        md   = longint'(1) << w;
        half = md >> 1;
        full = m ? (x - y) : (x + y);
        r    = ((full % md) + md) % md;
        c    = m ? (x >= y) : (full >= md);
        sx   = (x >= half) ? x - md : x;
        sy   = (y >= half) ? y - md : y;
        sr   = m ? (sx - sy) : (sx + sy);
        v    = (sr >= half) || (sr < -half);
        return {c, v, 32'(r)};
    endfunction

    // Timing model: age = edges since the accepted start, -1 when nothing pending.
    int          age = -1;
    logic [33:0] cur_op = '0;
    logic [33:0] fin_op = '0;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            age      <= -1;
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
        end else begin
            exp_busy <= (age >= 0) && (age < W);
            exp_done <= (age == W);
            if (age == W) fin_op <= cur_op;
            if (start && (age < 0 || age >= W)) begin
                age    <= 0;
                cur_op <= ref_op(W, mode, longint'(a), longint'(b));
            end else if (age >= 0) begin
                age <= (age >= W + 1) ? -1 : age + 1;
            end
        end
    end

    // Per-cycle compare of the 8-bit instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_busy", 32'(busy), 32'(exp_busy));
            chk("m_done", 32'(done), 32'(exp_done));
            if (exp_done) begin
                chk("m_result", 32'(result), fin_op[31:0]);
                chk("m_cout_ovf", 32'({cout, ovf}), 32'(fin_op[33:32]));
            end
        end
    end

    task automatic run_op(input string nm, input logic m, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] er, input logic ec, input logic ev);
        int n;
        @(negedge clk); start = 1'b1; mode = m; a = x; b = y;
        @(negedge clk); start = 1'b0; mode = ~m; a = ~x; b = 8'h5A;
        n = 1;
        while (!done && n < 20) begin @(negedge clk); n++; end
        chk({nm, "_lat"}, 32'(n), 32'd10);
        chk({nm, "_res"}, 32'(result), 32'(er));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
        chk({nm, "_ovf"}, 32'(ovf), 32'(ev));
        repeat (3) @(negedge clk);
        chk({nm, "_hold"}, 32'({result, cout, ovf}), 32'({er, ec, ev}));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bc, dc, dn, n;
        logic [7:0]  rr, r1, r2;
        logic [1:0]  cv1, cv2;
        int          t1, t2;
        logic [33:0] e;

        rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
        start4 = 1'b0; mode4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'({busy, done, result, cout, ovf}), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        run_op("add_0f_01", 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
        run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        run_op("sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
        run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

        // Start pulse during RUN must be ignored.
        bc = 0; dc = 0; dn = 0; rr = '0;
        @(negedge clk); start = 1'b1; mode = 1'b0; a = 8'h10; b = 8'h20;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            start = (i == 3);
            if (i == 3) begin mode = 1'b1; a = 8'h01; b = 8'h01; end
            if (busy) bc++;
            if (done) begin dc++; rr = result; dn = i; end
        end
        start = 1'b0;
        chk("ign_busy_cycles", 32'(bc), 32'd8);
        chk("ign_done_count", 32'(dc), 32'd1);
        chk("ign_done_time", 32'(dn), 32'd10);
        chk("ign_result", 32'(rr), 32'h30);

        // Reset in the 4th RUN cycle abandons the operation.
        @(negedge clk); start = 1'b1; mode = 1'b0; a = 8'h55; b = 8'h11;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_result", 32'(result), 32'd0);
        dc = 0;
        repeat (12) begin @(negedge clk); if (done) dc++; end
        chk("rst_mid_no_done", 32'(dc), 32'd0);
        run_op("add_03_04", 1'b0, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0);

        // Back-to-back: start held high through DONE.
        dc = 0; t1 = 0; t2 = 0; r1 = '0; r2 = '0; cv1 = '0; cv2 = '0;
        @(negedge clk); start = 1'b1; mode = 1'b0; a = 8'h12; b = 8'h34;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (i == 1) begin mode = 1'b1; a = 8'h50; b = 8'h60; end
            if (done) begin
                dc++;
                if (dc == 1) begin r1 = result; cv1 = {cout, ovf}; t1 = i; start = 1'b0; end
                else begin r2 = result; cv2 = {cout, ovf}; t2 = i; end
            end
        end
        start = 1'b0;
        chk("b2b_count", 32'(dc), 32'd2);
        chk("b2b_t1", 32'(t1), 32'd10);
        chk("b2b_t2", 32'(t2), 32'd19);
        chk("b2b_r1", 32'({r1, cv1}), 32'({8'h46, 2'b00}));
        chk("b2b_r2", 32'({r2, cv2}), 32'({8'hF0, 2'b00}));

        // Exhaustive sweep of the 4-bit instance.
        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    @(negedge clk); start4 = 1'b1; mode4 = m[0]; a4 = x[3:0]; b4 = y[3:0];
                    @(negedge clk); start4 = 1'b0; a4 = ~x[3:0]; b4 = y[3:0] ^ 4'hA;
                    n = 0;
                    while (!done4 && n < 30) begin @(negedge clk); n++; end
                    e = ref_op(4, m[0], longint'(x), longint'(y));
                    chk("x4_done", 32'(done4), 32'd1);
                    chk("x4_res", 32'(result4), e[31:0]);
                    chk("x4_cout_ovf", 32'({cout4, ovf4}), 32'(e[33:32]));
                end
            end
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
